// File: rtl/imem_boot_rom_pkg.sv
// Shared constants and state type for the boot-loadable instruction memory.
package imem_boot_rom_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {IMEM_LOAD, IMEM_RUN} imem_state_t;

endpackage

// File: rtl/imem_bram_2r1w.sv
// DEPTH x DATA_W storage with two registered read ports and one write port; no reset on storage.
module imem_bram_2r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (ren) begin
      rdata0 <= mem[raddr0];
      rdata1 <= mem[raddr1];
    end
  end

endmodule

// File: rtl/imem_boot_rom.sv
// Dual-read-port instruction memory with a valid/ready boot-load stream.
//   state     | meaning
//   IMEM_LOAD | accepting image words at load_ptr; fetch reads ignored
//   IMEM_RUN  | serving fetch reads; load_start re-enters IMEM_LOAD
module imem_boot_rom
  import imem_boot_rom_pkg::*;
#(
  parameter int INSTR_W   = XLEN,
  parameter int PC_W      = XLEN,
  parameter int DEPTH     = 1024,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_ren,
  input  logic [PC_W-1:0]    imem_addr0,
  input  logic [PC_W-1:0]    imem_addr1,
  output logic [INSTR_W-1:0] imem_rdata0,
  output logic [INSTR_W-1:0] imem_rdata1,
  output logic               imem_rvalid,
  output logic [1:0]         imem_err,
  output logic               imem_ready,
  input  logic               load_start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);
  localparam imem_state_t RESET_STATE = BOOT_LOAD ? IMEM_LOAD : IMEM_RUN;
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  imem_state_t       state, state_nxt;
  logic [AW-1:0]     load_ptr;
  logic              accept, load_fin, rd_fire;
  logic [1:0]        oor, mis, nop_sel;
  logic [INSTR_W-1:0] bram_q0, bram_q1;

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    imem_ready = 1'b0;
    accept     = 1'b0;
    load_fin   = 1'b0;
    case (state)
      IMEM_LOAD: begin
        load_ready = 1'b1;
        accept     = load_valid;
        load_fin   = accept && (load_last || load_ptr == PTR_MAX);
        if (load_fin) state_nxt = IMEM_RUN;
      end
      IMEM_RUN: begin
        imem_ready = 1'b1;
        if (load_start) state_nxt = IMEM_LOAD;
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  assign load_done = load_fin;
  assign rd_fire   = (state == IMEM_RUN) && imem_ren;

  assign oor[0] = |imem_addr0[PC_W-1:AW+2];
  assign oor[1] = |imem_addr1[PC_W-1:AW+2];
  assign mis[0] = |imem_addr0[1:0];
  assign mis[1] = |imem_addr1[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RESET_STATE;
      load_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IMEM_RUN && load_start)
        load_ptr <= '0;
      else if (accept && load_ptr != PTR_MAX)
        load_ptr <= load_ptr + 1'b1;
    end
  end

  // nop_sel masks the BRAM output so reset and out-of-range reads show NOP without touching storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_rvalid <= 1'b0;
      imem_err    <= 2'b00;
      nop_sel     <= 2'b11;
    end else begin
      imem_rvalid <= rd_fire;
      if (rd_fire) begin
        imem_err <= oor | mis;
        nop_sel  <= oor;
      end else begin
        imem_err <= 2'b00;
      end
    end
  end

  imem_bram_2r1w #(
    .DATA_W(INSTR_W),
    .DEPTH (DEPTH),
    .ADDR_W(AW)
  ) u_bram (
    .clk   (clk),
    .ren   (rd_fire),
    .raddr0(imem_addr0[AW+1:2]),
    .raddr1(imem_addr1[AW+1:2]),
    .rdata0(bram_q0),
    .rdata1(bram_q1),
    .we    (accept),
    .waddr (load_ptr),
    .wdata (load_data)
  );

  assign imem_rdata0 = nop_sel[0] ? NOP : bram_q0;
  assign imem_rdata1 = nop_sel[1] ? NOP : bram_q1;

endmodule

// File: tb/tb_imem_boot_rom.sv
// Directed bench for imem_boot_rom with a behavioural memory model checked every cycle.
module tb_imem_boot_rom;

  localparam int D = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ren = 1'b0;
  logic [31:0] imem_addr0 = '0;
  logic [31:0] imem_addr1 = '0;
  logic [31:0] imem_rdata0, imem_rdata1;
  logic        imem_rvalid, imem_ready;
  logic [1:0]  imem_err;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_done;

  int n_chk = 0;
  int n_fail = 0;

  imem_boot_rom #(
    .INSTR_W  (32),
    .PC_W     (32),
    .DEPTH    (D),
    .BOOT_LOAD(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_ren   (imem_ren),
    .imem_addr0 (imem_addr0),
    .imem_addr1 (imem_addr1),
    .imem_rdata0(imem_rdata0),
    .imem_rdata1(imem_rdata1),
    .imem_rvalid(imem_rvalid),
    .imem_err   (imem_err),
    .imem_ready (imem_ready),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory image, written flags, and the expected registered outputs.
  bit          m_run = 1'b0;
  int          m_ptr = 0;
  logic [31:0] m_mem [D];
  bit          m_wr [D];
  logic [31:0] m_rd [2] = '{NOP, NOP};
  bit          m_kn [2] = '{1'b1, 1'b1};
  bit          m_rv = 1'b0;
  bit   [1:0]  m_err = 2'b00;
  logic [31:0] m_a;
  int          m_idx;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 1'b0;
      m_ptr = 0;
      m_rd[0] = NOP; m_rd[1] = NOP;
      m_kn[0] = 1'b1; m_kn[1] = 1'b1;
      m_rv = 1'b0;
      m_err = 2'b00;
    end else if (!m_run) begin
      m_rv = 1'b0;
      m_err = 2'b00;
      if (load_valid) begin
        m_mem[m_ptr] = load_data;
        m_wr[m_ptr] = 1'b1;
        if (load_last || m_ptr == D - 1) m_run = 1'b1;
        if (m_ptr < D - 1) m_ptr = m_ptr + 1;
      end
    end else begin
      m_rv = imem_ren;
      m_err = 2'b00;
      if (imem_ren) begin
        for (int p = 0; p < 2; p++) begin
          m_a = (p == 0) ? imem_addr0 : imem_addr1;
          m_idx = int'((m_a / 4) % D);
          if (m_a >= D * 4) begin
            m_rd[p] = NOP; m_kn[p] = 1'b1; m_err[p] = 1'b1;
          end else begin
            m_rd[p] = m_mem[m_idx]; m_kn[p] = m_wr[m_idx]; m_err[p] = (m_a % 4) != 0;
          end
        end
      end
      if (load_start) begin
        m_run = 1'b0;
        m_ptr = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic exp_done;
    exp_done = !m_run && load_valid && (load_last || m_ptr == D - 1);
    chk("imem_ready", 32'(imem_ready), 32'(m_run));
    chk("load_ready", 32'(load_ready), 32'(!m_run));
    chk("load_done", 32'(load_done), 32'(exp_done));
    chk("imem_rvalid", 32'(imem_rvalid), 32'(m_rv));
    chk("imem_err", 32'(imem_err), 32'(m_err));
    if (m_kn[0]) chk("imem_rdata0", imem_rdata0, m_rd[0]);
    if (m_kn[1]) chk("imem_rdata1", imem_rdata1, m_rd[1]);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [31:0] a0, input logic [31:0] a1);
    imem_ren = 1'b1; imem_addr0 = a0; imem_addr1 = a1;
    tick();
    imem_ren = 1'b0;
  endtask

  initial begin
    // T1: reset with boot load enabled
    repeat (3) tick();
    chk("t1_imem_ready", 32'(imem_ready), 32'd0);
    chk("t1_load_ready", 32'(load_ready), 32'd1);
    chk("t1_rdata0", imem_rdata0, 32'h0000_0013);
    chk("t1_rdata1", imem_rdata1, 32'h0000_0013);
    reset = 1'b1;
    tick();

    // T2: six-word image, last on the sixth
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_data = 32'(32'h1111_1111 * (i + 1));
      load_last = (i == 5);
      if (i == 5) begin
        #1;
        chk("t2_load_done", 32'(load_done), 32'd1);
      end
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("t2_imem_ready", 32'(imem_ready), 32'd1);
    chk("t2_done_low", 32'(load_done), 32'd0);

    // T3/T4: read then hold
    rd(32'h00, 32'h04);
    chk("t3_rdata0", imem_rdata0, 32'h1111_1111);
    chk("t3_rdata1", imem_rdata1, 32'h2222_2222);
    chk("t3_rvalid", 32'(imem_rvalid), 32'd1);
    tick(); tick();
    chk("t4_rdata0", imem_rdata0, 32'h1111_1111);
    chk("t4_rdata1", imem_rdata1, 32'h2222_2222);
    chk("t4_rvalid", 32'(imem_rvalid), 32'd0);

    // T5: out of range and misaligned
    rd(D * 4, 32'h0A);
    chk("t5_rdata0", imem_rdata0, 32'h0000_0013);
    chk("t5_err", 32'(imem_err), 32'd3);
    chk("t5_rdata1", imem_rdata1, 32'h3333_3333);
    rd(32'h15, 32'h08);
    chk("t5b_rdata0", imem_rdata0, 32'h6666_6666);
    chk("t5b_rdata1", imem_rdata1, 32'h3333_3333);
    chk("t5b_err", 32'(imem_err), 32'd1);
    rd(32'h0C, 32'h0C);
    chk("same_idx0", imem_rdata0, 32'h4444_4444);
    chk("same_idx1", imem_rdata1, 32'h4444_4444);

    // T6: read alongside load_start sees old data, then reset mid-load
    load_start = 1'b1;
    rd(32'h10, 32'h14);
    load_start = 1'b0;
    chk("t6_old_rdata0", imem_rdata0, 32'h5555_5555);
    chk("t6_old_rdata1", imem_rdata1, 32'h6666_6666);
    chk("t6_rvalid", 32'(imem_rvalid), 32'd1);
    chk("t6_in_load", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data = 32'hA0A0_A0A0; tick();
    load_data = 32'hB1B1_B1B1; tick();
    load_valid = 1'b0;
    rd(32'h00, 32'h04);
    chk("t6_load_rd_hold", imem_rdata0, 32'h5555_5555);
    chk("t6_load_rd_rvalid", 32'(imem_rvalid), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6_rst_rdata0", imem_rdata0, 32'h0000_0013);
    chk("t6_rst_load_ready", 32'(load_ready), 32'd1);
    reset = 1'b1;
    tick();
    load_valid = 1'b1; load_data = 32'hC2C2_C2C2; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    rd(32'h00, 32'h04);
    chk("t6_ptr0_word0", imem_rdata0, 32'hC2C2_C2C2);
    chk("t6_word1", imem_rdata1, 32'hB1B1_B1B1);
    rd(32'h08, 32'h0C);
    chk("t6_word2_kept", imem_rdata0, 32'h3333_3333);
    chk("t6_word3_kept", imem_rdata1, 32'h4444_4444);

    // T7: full image with no last; forced transition at DEPTH-1
    load_start = 1'b1; tick(); load_start = 1'b0;
    chk("t7_in_load", 32'(imem_ready), 32'd0);
    for (int i = 0; i < D; i++) begin
      load_valid = 1'b1;
      load_data = 32'hF000_0000 + 32'(i);
      load_start = (i == 3);
      if (i == D - 1) begin
        #1;
        chk("t7_load_done", 32'(load_done), 32'd1);
      end
      tick();
    end
    load_valid = 1'b0; load_start = 1'b0;
    chk("t7_imem_ready", 32'(imem_ready), 32'd1);
    rd(32'h3C, 32'h00);
    chk("t7_top_word", imem_rdata0, 32'hF000_000F);
    chk("t7_word0", imem_rdata1, 32'hF000_0000);
    rd(32'h38, 32'h40);
    chk("t7_word14", imem_rdata0, 32'hF000_000E);
    chk("t7_oor1", imem_rdata1, 32'h0000_0013);
    chk("t7_err", 32'(imem_err), 32'd2);
    tick();
    chk("end_err_clear", 32'(imem_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
